phy_reg_free_list: RTL

// - Allocator for physical registers: a circular FIFO of free physical register indices.
// - Rename grants a free physical destination per instruction. Commit returns retired registers.
// - Sequences the register status table: drives its new_valid_inst / dst_reg_addr pair on every

---
 rtl/rs_pkg.sv | 12 +
 rtl/phy_reg_free_list.sv | 52 +++++
 2 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared physical-register types and sizing for rename / reservation-station logic.
`ifndef PHYSICAL_REG_NUM
`define PHYSICAL_REG_NUM 64
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
package rs_pkg;
  localparam int PHYSICAL_REG_NUM = `PHYSICAL_REG_NUM;
  localparam int ARCH_REG_NUM = 32;
  typedef logic [`PHYSICAL_REG_NUM_WIDTH-1:0] phy_reg_addr_t;
endpackage

// File: rtl/phy_reg_free_list.sv
// phy_reg_free_list: circular FIFO of free physical registers, granting one per cycle to rename.
module phy_reg_free_list #(
  parameter int ARCH_REG_NUM = rs_pkg::ARCH_REG_NUM,
  parameter int FL_DEPTH = rs_pkg::PHYSICAL_REG_NUM - rs_pkg::ARCH_REG_NUM,
  localparam int PW = FL_DEPTH > 1 ? $clog2(FL_DEPTH) : 1,
  localparam int CW = $clog2(FL_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output rs_pkg::phy_reg_addr_t alloc_reg_addr,
  output logic                  new_valid_inst,
  output rs_pkg::phy_reg_addr_t dst_reg_addr,
  input  logic                  free_valid,
  input  rs_pkg::phy_reg_addr_t free_reg_addr,
  output logic [CW-1:0]         free_count,
  output logic                  fl_empty,
  output logic                  fl_overflow_err
);
  rs_pkg::phy_reg_addr_t entry [FL_DEPTH];
  logic [PW-1:0] head, tail;
  logic full, do_alloc, do_free, drop;
  always_comb begin
    alloc_gnt = free_count != '0;
    alloc_reg_addr = entry[head];
    new_valid_inst = alloc_req & alloc_gnt;
    dst_reg_addr = alloc_reg_addr;
    fl_empty = free_count == '0;
    full = free_count == CW'(FL_DEPTH);
    do_alloc = new_valid_inst;
    do_free = free_valid & |free_reg_addr & ~full;
    drop = free_valid & |free_reg_addr & full;
  end
  // FL_DEPTH may be non-power-of-2, so wrap by compare rather than by natural overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) entry[i] <= rs_pkg::phy_reg_addr_t'(ARCH_REG_NUM + i);
      head <= '0;
      tail <= '0;
      free_count <= CW'(FL_DEPTH);
      fl_overflow_err <= 1'b0;
    end else begin
      if (do_alloc) head <= head == PW'(FL_DEPTH - 1) ? '0 : head + PW'(1);
      if (do_free) begin
        entry[tail] <= free_reg_addr;
        tail <= tail == PW'(FL_DEPTH - 1) ? '0 : tail + PW'(1);
      end
      if (do_alloc != do_free) free_count <= do_free ? free_count + CW'(1) : free_count - CW'(1);
      if (drop) fl_overflow_err <= 1'b1;
    end
endmodule
